// File: rtl/shift_sequencer.sv
// shift_sequencer
//   Full-duplex serial engine built around a right-shifting register. It accepts
//   a parallel word over valid/ready and shifts it out LSB-first on ser_out, one
//   bit every DIV clocks. On each shift it also captures ser_in into the MSB, and
//   it presents the assembled word on rx_data with a one-cycle rx_valid pulse.
//
// Ports
//   clk, rstb          clock (rising edge); asynchronous active-high reset
//   tx_data/tx_valid   word offered for transmission
//   tx_ready           registered; high in IDLE when a word can be accepted
//   abort              synchronous cancel of the word in flight (SHIFT/DONE)
//   ser_in / ser_out   serial input (sampled on strobes) / serial output
//   shift_en           high in the cycle whose closing edge performs a shift
//   busy               high whenever the FSM is not in IDLE
//   rx_data/rx_valid   received word, valid during the one-cycle rx_valid pulse
module shift_sequencer #(
    parameter int WIDTH = 8,
    parameter int DIV   = 4
) (
    input  logic             clk,
    input  logic             rstb,
    input  logic [WIDTH-1:0] tx_data,
    input  logic             tx_valid,
    output logic             tx_ready,
    input  logic             abort,
    input  logic             ser_in,
    output logic             ser_out,
    output logic             shift_en,
    output logic             busy,
    output logic [WIDTH-1:0] rx_data,
    output logic             rx_valid
);
    localparam int DCW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int BCW = $clog2(WIDTH);
    localparam logic [DCW-1:0] DIV_LAST = DCW'(DIV - 1);
    localparam logic [BCW-1:0] BIT_LAST = BCW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [BCW-1:0]   bit_cnt_q, bit_cnt_d;
    logic [DCW-1:0]   div_cnt_q, div_cnt_d;
    logic             tx_ready_q, tx_ready_d;
    logic [WIDTH-1:0] rx_data_q, rx_data_d;
    logic             rx_valid_q, rx_valid_d;

    logic             accept;
    logic             strobe;
    logic             last_bit;
    logic [WIDTH-1:0] shreg_nxt;

    // tx_ready_q is only ever high in IDLE, so it alone qualifies the accept.
    assign accept    = tx_valid && tx_ready_q;
    assign strobe    = (state_q == SHIFT) && (div_cnt_q == DIV_LAST);
    assign last_bit  = (bit_cnt_q == BIT_LAST);
    assign shreg_nxt = {ser_in, shreg_q[WIDTH-1:1]};

    // State and datapath registers
    always_ff @(posedge clk or posedge rstb) begin
        if (rstb) begin
            state_q    <= IDLE;
            shreg_q    <= '0;
            bit_cnt_q  <= '0;
            div_cnt_q  <= '0;
            tx_ready_q <= 1'b0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            shreg_q    <= shreg_d;
            bit_cnt_q  <= bit_cnt_d;
            div_cnt_q  <= div_cnt_d;
            tx_ready_q <= tx_ready_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
        end
    end

    // Next state; abort wins over a coincident final strobe.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (accept) state_d = SHIFT;
            SHIFT: begin
                if (abort)                   state_d = IDLE;
                else if (strobe && last_bit) state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath next values
    always_comb begin
        shreg_d    = shreg_q;
        bit_cnt_d  = bit_cnt_q;
        div_cnt_d  = div_cnt_q;
        tx_ready_d = tx_ready_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    shreg_d    = tx_data;
                    bit_cnt_d  = '0;
                    div_cnt_d  = '0;
                    tx_ready_d = 1'b0;
                end else begin
                    tx_ready_d = 1'b1;
                end
            end
            SHIFT: begin
                if (abort) begin
                    shreg_d    = '0;
                    bit_cnt_d  = '0;
                    div_cnt_d  = '0;
                    tx_ready_d = 1'b1;
                end else begin
                    div_cnt_d = strobe ? '0 : div_cnt_q + DCW'(1);
                    if (strobe) begin
                        shreg_d = shreg_nxt;
                        if (last_bit) begin
                            rx_data_d  = shreg_nxt;
                            rx_valid_d = 1'b1;
                            bit_cnt_d  = '0;
                        end else begin
                            bit_cnt_d = bit_cnt_q + BCW'(1);
                        end
                    end
                end
            end
            DONE: begin
                if (abort) begin
                    shreg_d   = '0;
                    bit_cnt_d = '0;
                    div_cnt_d = '0;
                end
                tx_ready_d = 1'b1;
            end
            default: begin
                tx_ready_d = 1'b1;
            end
        endcase
    end

    // Outputs
    always_comb begin
        ser_out  = (state_q == SHIFT) ? shreg_q[0] : 1'b0;
        shift_en = strobe;
        busy     = (state_q != IDLE);
        tx_ready = tx_ready_q;
        rx_data  = rx_data_q;
        rx_valid = rx_valid_q;
    end

endmodule

// File: tb/tb_shift_sequencer.sv
// Bench for shift_sequencer: a DIV=4 instance driven with directed and random
// words (loopback or bench-driven ser_in patterns, aborts), plus a DIV=1 loopback
// instance. Expected received words go into queues; monitors pop on rx_valid.
module tb_shift_sequencer;
    localparam int W    = 8;
    localparam int D    = 4;
    localparam int BITS = W * D;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // DIV=4 instance
    logic [W-1:0] tx_data = '0, rx_data;
    logic tx_valid = 1'b0, abort = 1'b0;
    logic tx_ready, ser_in, ser_out, shift_en, busy, rx_valid;
    logic loop_mode = 1'b1, pat_bit = 1'b0;
    assign ser_in = loop_mode ? ser_out : pat_bit;

    shift_sequencer #(.WIDTH(W), .DIV(D)) dut (
        .clk(clk), .rstb(rst), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(tx_ready), .abort(abort), .ser_in(ser_in), .ser_out(ser_out),
        .shift_en(shift_en), .busy(busy), .rx_data(rx_data), .rx_valid(rx_valid)
    );

    // DIV=1 instance, always in loopback
    logic [W-1:0] tx_data1 = '0, rx_data1;
    logic tx_valid1 = 1'b0, abort1 = 1'b0;
    logic tx_ready1, ser_out1, shift_en1, busy1, rx_valid1;

    shift_sequencer #(.WIDTH(W), .DIV(1)) dut1 (
        .clk(clk), .rstb(rst), .tx_data(tx_data1), .tx_valid(tx_valid1),
        .tx_ready(tx_ready1), .abort(abort1), .ser_in(ser_out1), .ser_out(ser_out1),
        .shift_en(shift_en1), .busy(busy1), .rx_data(rx_data1), .rx_valid(rx_valid1)
    );

    int n_chk  = 0;
    int n_fail = 0;
    logic [W-1:0] q4[$];
    logic [W-1:0] q1[$];
    logic [W-1:0] last_rx = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard monitors
    always @(negedge clk) begin : mon4
        logic [W-1:0] e;
        if (rx_valid === 1'b1) begin
            if (q4.size() == 0) chk("rx4_unexpected", 32'(rx_data), 32'hFFFF_FFFF);
            else begin
                e = q4.pop_front();
                chk("rx4_data", 32'(rx_data), 32'(e));
            end
        end
    end

    always @(negedge clk) begin : mon1
        logic [W-1:0] e;
        if (rx_valid1 === 1'b1) begin
            if (q1.size() == 0) chk("rx1_unexpected", 32'(rx_data1), 32'hFFFF_FFFF);
            else begin
                e = q1.pop_front();
                chk("rx1_data", 32'(rx_data1), 32'(e));
            end
        end
    end

    // One transfer on the DIV=4 instance with cycle-by-cycle timing checks.
    // Cycle n is the cycle after edge E0+n. abort_n >= 0 pulses abort in cycle n.
    task automatic send(input logic [W-1:0] d, input bit lb, input logic [W-1:0] pat,
                        input int abort_n, input bit hold, input logic [W-1:0] next_d,
                        input bit b2b);
        int guard = 0;
        bit aborted = 1'b0;
        logic [W-1:0] exp_w;
        tx_data   = d;
        tx_valid  = 1'b1;
        loop_mode = lb;
        pat_bit   = 1'b0;
        while (tx_ready !== 1'b1 && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (tx_ready !== 1'b1) begin
            chk("tx_ready_timeout", 32'(tx_ready), 32'(1));
            tx_valid = 1'b0;
            return;
        end
        if (b2b) chk("b2b_no_gap", 32'(guard), 32'(0));
        @(posedge clk);
        #1;
        exp_w = lb ? d : pat;
        // An abort in the DONE cycle comes too late to suppress the word.
        if (abort_n < 0 || abort_n == BITS) begin
            q4.push_back(exp_w);
            last_rx = exp_w;
        end
        if (hold) tx_data = next_d;
        else      tx_valid = 1'b0;
        for (int n = 0; n <= BITS; n++) begin
            if (n < BITS) pat_bit = pat[n/D];
            if (n == abort_n) abort = 1'b1;
            @(negedge clk);
            chk("busy", 32'(busy), 32'(1));
            chk("tx_ready_low", 32'(tx_ready), 32'(0));
            chk("rx_valid", 32'(rx_valid), 32'(n == BITS));
            chk("ser_out", 32'(ser_out), 32'((n < BITS) ? d[n/D] : 1'b0));
            if (n != abort_n) chk("shift_en", 32'(shift_en), 32'(((n + 1) % D == 0) && (n < BITS)));
            @(posedge clk);
            #1;
            if (n == abort_n) begin
                abort   = 1'b0;
                aborted = 1'b1;
                break;
            end
        end
        pat_bit = 1'b0;
        @(negedge clk);
        chk("idle_busy", 32'(busy), 32'(0));
        chk("idle_tx_ready", 32'(tx_ready), 32'(1));
        chk("idle_rx_valid", 32'(rx_valid), 32'(0));
        chk("idle_ser_out", 32'(ser_out), 32'(0));
        if (aborted) chk("abort_rx_retained", 32'(rx_data), 32'(last_rx));
    endtask

    task automatic send1(input logic [W-1:0] d);
        int guard = 0;
        tx_data1  = d;
        tx_valid1 = 1'b1;
        while (tx_ready1 !== 1'b1 && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (tx_ready1 !== 1'b1) begin
            chk("d1_tx_ready_timeout", 32'(tx_ready1), 32'(1));
            tx_valid1 = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        tx_valid1 = 1'b0;
        q1.push_back(d);
        for (int n = 0; n <= W; n++) begin
            @(negedge clk);
            chk("d1_shift_en", 32'(shift_en1), 32'(n < W));
            chk("d1_rx_valid", 32'(rx_valid1), 32'(n == W));
            chk("d1_ser_out", 32'(ser_out1), 32'((n < W) ? d[n] : 1'b0));
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        chk("d1_tx_ready", 32'(tx_ready1), 32'(1));
        chk("d1_busy", 32'(busy1), 32'(0));
    endtask

    logic [W-1:0] rd, rp;
    bit           rlb;
    int           rab;

    initial begin
        // Reset state
        #1;
        chk("rst_tx_ready", 32'(tx_ready), 32'(0));
        chk("rst_busy", 32'(busy), 32'(0));
        chk("rst_rx_valid", 32'(rx_valid), 32'(0));
        chk("rst_rx_data", 32'(rx_data), 32'(0));
        chk("rst_ser_out", 32'(ser_out), 32'(0));
        chk("rst_shift_en", 32'(shift_en), 32'(0));
        #20;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rel_tx_ready_low", 32'(tx_ready), 32'(0));
        @(posedge clk);
        #1;
        chk("rel_tx_ready_high", 32'(tx_ready), 32'(1));

        // Directed cases
        send(8'hA5, 1'b1, 8'h00, -1, 1'b0, 8'h00, 1'b0);
        send(8'h00, 1'b0, 8'hFF, -1, 1'b0, 8'h00, 1'b0);
        send(8'h00, 1'b0, 8'h03, -1, 1'b0, 8'h00, 1'b0);
        send(8'h3C, 1'b1, 8'h00, -1, 1'b1, 8'hC3, 1'b0);
        send(8'hC3, 1'b1, 8'h00, -1, 1'b0, 8'h00, 1'b1);
        send(8'h77, 1'b1, 8'h00, 4*D-1, 1'b0, 8'h00, 1'b0);
        send(8'h5A, 1'b1, 8'h00, -1, 1'b0, 8'h00, 1'b0);
        send(8'h69, 1'b1, 8'h00, BITS, 1'b0, 8'h00, 1'b0);

        // Random transfers, some aborted
        for (int i = 0; i < 10; i++) begin
            rd  = W'($urandom);
            rp  = W'($urandom);
            rlb = 1'($urandom_range(0, 1));
            rab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, BITS)) : -1;
            repeat ($urandom_range(0, 3)) @(negedge clk);
            send(rd, rlb, rp, rab, 1'b0, 8'h00, 1'b0);
        end

        // Reset in the middle of a transfer
        tx_data   = 8'h96;
        tx_valid  = 1'b1;
        loop_mode = 1'b1;
        @(posedge clk);
        #1;
        tx_valid = 1'b0;
        repeat (10) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("mid_rst_tx_ready", 32'(tx_ready), 32'(0));
        chk("mid_rst_busy", 32'(busy), 32'(0));
        chk("mid_rst_shift_en", 32'(shift_en), 32'(0));
        chk("mid_rst_ser_out", 32'(ser_out), 32'(0));
        chk("mid_rst_rx_valid", 32'(rx_valid), 32'(0));
        chk("mid_rst_rx_data", 32'(rx_data), 32'(0));
        @(negedge clk);
        rst     = 1'b0;
        last_rx = '0;
        #1;
        chk("mid_rel_tx_ready_low", 32'(tx_ready), 32'(0));
        @(posedge clk);
        #1;
        chk("mid_rel_tx_ready_high", 32'(tx_ready), 32'(1));
        send(8'hE1, 1'b1, 8'h00, -1, 1'b0, 8'h00, 1'b0);

        // DIV=1 loopback
        send1(8'h81);
        send1(W'($urandom));

        repeat (3) @(negedge clk);
        chk("q4_drained", 32'(q4.size()), 32'(0));
        chk("q1_drained", 32'(q1.size()), 32'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    // Absolute safety net against a hung bench
    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
